// File: rtl/fire_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fire_arbiter
//  Purpose  : Turn-based fire-button arbiter for a two-player shooting game.
//             Detects button presses, accepts only the player owning the
//             turn, and hands the latched target coordinate to the game core
//             over a valid/ready handshake. Turn alternates after each shot.
//  Ports    : clk            game clock (divided 50 Hz), rising edge
//             rst            asynchronous reset, active low
//             enable         shooting phase active (level)
//             first_player   owner of the first turn (0 = A, 1 = B)
//             pA_btn/pB_btn  debounced button levels
//             xy             target coordinate {X[1:0], Y[1:0]}
//             shot_valid/shot_ready  shot handshake to the game core
//             shot_player    shooter of the pending shot
//             shot_xy        latched coordinate of the pending shot
//             turn           player currently owning the turn
//             illegal        one-cycle pulse on an out-of-turn press
//             timeout        one-cycle pulse when a turn is forfeited
//             shot_count     accepted shots since IDLE, saturating at 255
//  Option   : FIRE_TIMEOUT_EN enables the idle-turn forfeit counter
//             (TIMEOUT_TICKS cycles, legal range 2..65535).
//  Revision : 1.0  initial release
// ============================================================================
module fire_arbiter #(
    parameter int unsigned TIMEOUT_TICKS = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       first_player,
    input  logic       pA_btn,
    input  logic       pB_btn,
    input  logic [3:0] xy,
    output logic       shot_valid,
    input  logic       shot_ready,
    output logic       shot_player,
    output logic [3:0] shot_xy,
    output logic       turn,
    output logic       illegal,
    output logic       timeout,
    output logic [7:0] shot_count
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_TURN  = 2'd1;
    localparam logic [1:0] c_ST_ISSUE = 2'd2;

    logic [1:0] r_state;
    logic       r_pa_q;
    logic       r_pb_q;

    logic w_pa_press;
    logic w_pb_press;
    logic w_own_press;
    logic w_other_press;
    logic w_expire;

    // Edge registers reset to 1 so a button held through reset release is
    // not mistaken for a fresh press.
    assign w_pa_press    = pA_btn & ~r_pa_q;
    assign w_pb_press    = pB_btn & ~r_pb_q;
    assign w_own_press   = turn ? w_pb_press : w_pa_press;
    assign w_other_press = turn ? w_pa_press : w_pb_press;

    // Out-of-range TIMEOUT_TICKS leaves an empty marker block in the
    // elaborated hierarchy; the parameter stays referenced in every build.
    if (TIMEOUT_TICKS < 2 || TIMEOUT_TICKS > 65535) begin : g_timeout_ticks_out_of_range
    end

`ifdef FIRE_TIMEOUT_EN
    localparam logic [15:0] c_TICKS_LAST = 16'(TIMEOUT_TICKS - 1);

    logic [15:0] r_idle_cnt;

    assign w_expire = (r_state == c_ST_TURN) && enable && (r_idle_cnt == c_TICKS_LAST);

    // Held at zero outside TURN, so every entry into TURN starts from zero.
    // A turn-player press leaves TURN and therefore beats a coinciding expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idle_cnt <= 16'd0;
        end else if (r_state != c_ST_TURN || !enable || w_own_press || w_expire) begin
            r_idle_cnt <= 16'd0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_pa_q      <= 1'b1;
            r_pb_q      <= 1'b1;
            shot_valid  <= 1'b0;
            shot_player <= 1'b0;
            shot_xy     <= 4'd0;
            turn        <= 1'b0;
            illegal     <= 1'b0;
            timeout     <= 1'b0;
            shot_count  <= 8'd0;
        end else begin
            r_pa_q  <= pA_btn;
            r_pb_q  <= pB_btn;
            illegal <= 1'b0;
            timeout <= 1'b0;

            if (!enable && r_state != c_ST_IDLE) begin
                // Leaving the phase aborts any pending shot without handshake.
                r_state    <= c_ST_IDLE;
                shot_valid <= 1'b0;
                shot_count <= 8'd0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        turn       <= first_player;
                        shot_count <= 8'd0;
                        if (enable) begin
                            r_state <= c_ST_TURN;
                        end
                    end
                    c_ST_TURN: begin
                        illegal <= w_other_press;
                        if (w_own_press) begin
                            shot_xy     <= xy;
                            shot_player <= turn;
                            shot_valid  <= 1'b1;
                            r_state     <= c_ST_ISSUE;
                        end else if (w_expire) begin
                            timeout <= 1'b1;
                            turn    <= ~turn;
                        end
                    end
                    c_ST_ISSUE: begin
                        // shot_valid is always high in ISSUE, so ready alone
                        // completes the handshake.
                        if (shot_ready) begin
                            shot_valid <= 1'b0;
                            turn       <= ~turn;
                            r_state    <= c_ST_TURN;
                            if (shot_count != 8'hFF) begin
                                shot_count <= shot_count + 8'd1;
                            end
                        end
                    end
                    default: begin
                        r_state    <= c_ST_IDLE;
                        shot_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fire_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fire_arbiter
//  Purpose  : Self-checking bench for fire_arbiter. Expected shots are pushed
//             to a queue when a press is driven and popped when the DUT
//             presents the shot on its handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fire_arbiter;

    typedef struct packed {
        logic       player;
        logic [3:0] xy;
    } shot_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       first_player;
    logic       pA_btn;
    logic       pB_btn;
    logic [3:0] xy;
    logic       shot_valid;
    logic       shot_ready;
    logic       shot_player;
    logic [3:0] shot_xy;
    logic       turn;
    logic       illegal;
    logic       timeout;
    logic [7:0] shot_count;

    int    n_cmp = 0;
    int    n_bad = 0;
    shot_t sb_q[$];

    fire_arbiter #(.TIMEOUT_TICKS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .first_player (first_player),
        .pA_btn       (pA_btn),
        .pB_btn       (pB_btn),
        .xy           (xy),
        .shot_valid   (shot_valid),
        .shot_ready   (shot_ready),
        .shot_player  (shot_player),
        .shot_xy      (shot_xy),
        .turn         (turn),
        .illegal      (illegal),
        .timeout      (timeout),
        .shot_count   (shot_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Return to IDLE, then enter TURN with the given first player.
    task automatic go_turn(input logic fp);
        enable = 1'b0;
        cyc();
        first_player = fp;
        enable = 1'b1;
        cyc();
        n_cmp++;
        if (turn !== fp || shot_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL go_turn: turn=%b valid=%b expected turn=%b valid=0", turn, shot_valid, fp);
        end
    endtask

    task automatic complete_shot();
        shot_t exp;
        int waited = 0;
        while (shot_valid !== 1'b1 && waited < 8) begin
            cyc();
            waited++;
        end
        n_cmp++;
        if (shot_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL shot_wait: shot_valid=%b expected 1 within 8 cycles", shot_valid);
        end else if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL shot_unexpected: got player=%b xy=%b expected no shot", shot_player, shot_xy);
        end else begin
            exp = sb_q.pop_front();
            if ({shot_player, shot_xy} !== exp) begin
                n_bad++;
                $display("FAIL shot_data: got player=%b xy=%b expected player=%b xy=%b",
                         shot_player, shot_xy, exp.player, exp.xy);
            end
        end
        shot_ready = 1'b1;
        cyc();
        shot_ready = 1'b0;
        n_cmp++;
        if (shot_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL shot_drop: shot_valid=%b expected 0 after handshake", shot_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; first_player = 1'b1;
        pA_btn = 1'b0; pB_btn = 1'b1; xy = 4'd0; shot_ready = 1'b0;
        repeat (2) cyc();
        n_cmp++;
        if ({shot_valid, shot_player, shot_xy, turn, illegal, timeout, shot_count} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %b expected all zero",
                     {shot_valid, shot_player, shot_xy, turn, illegal, timeout, shot_count});
        end
        rst = 1'b1;
        cyc();
        n_cmp++;
        if (turn !== 1'b1 || shot_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: turn=%b valid=%b expected turn=1 valid=0", turn, shot_valid);
        end
        cyc();
        n_cmp++;
        if (shot_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL held_button: shot_valid=%b expected 0", shot_valid);
        end
        pB_btn = 1'b0;
        cyc();
    endtask

    task automatic test_shot();
        go_turn(1'b0);
        xy = 4'b1001;
        sb_q.push_back('{player: 1'b0, xy: 4'b1001});
        pA_btn = 1'b1;
        cyc();
        pA_btn = 1'b0;
        xy = 4'b0110;
        for (int i = 1; i <= 5; i++) begin
            n_cmp++;
            if (shot_valid !== 1'b1 || shot_xy !== 4'b1001 || shot_player !== 1'b0 || illegal !== 1'b0) begin
                n_bad++;
                $display("FAIL issue_hold[%0d]: valid=%b xy=%b player=%b illegal=%b expected 1 1001 0 0",
                         i, shot_valid, shot_xy, shot_player, illegal);
            end
            pB_btn = (i == 2);
            cyc();
        end
        complete_shot();
        n_cmp++;
        if (turn !== 1'b1 || shot_count !== 8'd1) begin
            n_bad++;
            $display("FAIL after_shot: turn=%b count=%0d expected turn=1 count=1", turn, shot_count);
        end
    endtask

    task automatic test_ready_ignored();
        shot_ready = 1'b1;
        repeat (2) cyc();
        shot_ready = 1'b0;
        n_cmp++;
        if (turn !== 1'b1 || shot_count !== 8'd1 || shot_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_idle: turn=%b count=%0d valid=%b expected 1 1 0", turn, shot_count, shot_valid);
        end
    endtask

    task automatic test_illegal();
        go_turn(1'b0);
        pB_btn = 1'b1;
        cyc();
        pB_btn = 1'b0;
        n_cmp++;
        if (illegal !== 1'b1 || shot_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_pulse: illegal=%b valid=%b expected 1 0", illegal, shot_valid);
        end
        cyc();
        n_cmp++;
        if (illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_width: illegal=%b expected 0", illegal);
        end
        xy = 4'b0101;
        sb_q.push_back('{player: 1'b0, xy: 4'b0101});
        pA_btn = 1'b1; pB_btn = 1'b1;
        cyc();
        pA_btn = 1'b0; pB_btn = 1'b0;
        n_cmp++;
        if (illegal !== 1'b1 || shot_valid !== 1'b1 || shot_player !== 1'b0) begin
            n_bad++;
            $display("FAIL both_press: illegal=%b valid=%b player=%b expected 1 1 0", illegal, shot_valid, shot_player);
        end
        complete_shot();
        pA_btn = 1'b1;
        cyc();
        pA_btn = 1'b0;
        n_cmp++;
        if (illegal !== 1'b1 || shot_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_b_turn: illegal=%b valid=%b expected 1 0", illegal, shot_valid);
        end
        xy = 4'b0011;
        sb_q.push_back('{player: 1'b1, xy: 4'b0011});
        pB_btn = 1'b1;
        cyc();
        pB_btn = 1'b0;
        complete_shot();
        n_cmp++;
        if (turn !== 1'b0 || shot_count !== 8'd2) begin
            n_bad++;
            $display("FAIL two_shots: turn=%b count=%0d expected 0 2", turn, shot_count);
        end
    endtask

    task automatic test_abort();
        xy = 4'b1110;
        pA_btn = 1'b1;
        cyc();
        pA_btn = 1'b0;
        enable = 1'b0;
        cyc();
        n_cmp++;
        if (shot_valid !== 1'b0 || shot_count !== 8'd0) begin
            n_bad++;
            $display("FAIL abort: valid=%b count=%0d expected 0 0", shot_valid, shot_count);
        end
        first_player = 1'b1;
        enable = 1'b1;
        cyc();
        n_cmp++;
        if (turn !== 1'b1 || shot_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle: turn=%b valid=%b expected 1 0", turn, shot_valid);
        end
    endtask

    task automatic test_reset_mid_issue();
        xy = 4'b1111;
        pB_btn = 1'b1;
        cyc();
        pB_btn = 1'b0;
        n_cmp++;
        if (shot_valid !== 1'b1 || shot_player !== 1'b1 || shot_xy !== 4'b1111) begin
            n_bad++;
            $display("FAIL pre_reset_issue: valid=%b player=%b xy=%b expected 1 1 1111", shot_valid, shot_player, shot_xy);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({shot_valid, shot_player, shot_xy, turn, illegal, timeout, shot_count} !== 17'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %b expected all zero",
                     {shot_valid, shot_player, shot_xy, turn, illegal, timeout, shot_count});
        end
        cyc();
        rst = 1'b1;
        shot_ready = 1'b1;
        repeat (2) cyc();
        shot_ready = 1'b0;
        n_cmp++;
        if (shot_valid !== 1'b0 || shot_count !== 8'd0 || turn !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset: valid=%b count=%0d turn=%b expected 0 0 1", shot_valid, shot_count, turn);
        end
    endtask

    task automatic test_saturate();
        logic et;
        logic [3:0] cxy;
        logic [7:0] ecount;
        go_turn(1'b0);
        et = 1'b0;
        for (int i = 0; i < 256; i++) begin
            cxy = 4'(i);
            xy = cxy;
            sb_q.push_back('{player: et, xy: cxy});
            if (et) pB_btn = 1'b1; else pA_btn = 1'b1;
            cyc();
            pA_btn = 1'b0; pB_btn = 1'b0;
            complete_shot();
            et = ~et;
            ecount = (i < 255) ? 8'(i + 1) : 8'd255;
            n_cmp++;
            if (shot_count !== ecount || turn !== et) begin
                n_bad++;
                $display("FAIL saturate[%0d]: count=%0d turn=%b expected %0d %b", i, shot_count, turn, ecount, et);
            end
        end
    endtask

`ifdef FIRE_TIMEOUT_EN
    task automatic test_timeout();
        go_turn(1'b0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            n_cmp++;
            if (timeout !== (i == 4) || turn !== (i == 4)) begin
                n_bad++;
                $display("FAIL timeout_first[%0d]: timeout=%b turn=%b expected %b %b", i, timeout, turn, i == 4, i == 4);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            cyc();
            n_cmp++;
            if (timeout !== (i == 4) || turn !== (i != 4)) begin
                n_bad++;
                $display("FAIL timeout_repeat[%0d]: timeout=%b turn=%b expected %b %b", i, timeout, turn, i == 4, i != 4);
            end
        end
        repeat (3) cyc();
        xy = 4'b1010;
        sb_q.push_back('{player: 1'b0, xy: 4'b1010});
        pA_btn = 1'b1;
        cyc();
        pA_btn = 1'b0;
        n_cmp++;
        if (timeout !== 1'b0 || shot_valid !== 1'b1 || turn !== 1'b0) begin
            n_bad++;
            $display("FAIL press_beats_timeout: timeout=%b valid=%b turn=%b expected 0 1 0", timeout, shot_valid, turn);
        end
        complete_shot();
        n_cmp++;
        if (shot_count !== 8'd1) begin
            n_bad++;
            $display("FAIL timeout_count: count=%0d expected 1", shot_count);
        end
    endtask
`else
    task automatic test_timeout();
        go_turn(1'b0);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            n_cmp++;
            if (timeout !== 1'b0 || turn !== 1'b0) begin
                n_bad++;
                $display("FAIL no_timeout[%0d]: timeout=%b turn=%b expected 0 0", i, timeout, turn);
            end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_shot();
        test_ready_ignored();
        test_illegal();
        test_abort();
        test_reset_mid_issue();
        test_saturate();
        test_timeout();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d shots outstanding, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fire_arbiter.md
FIRE_ARBITER -- requirements
Module: fire_arbiter

Interface
REQ-001 Parameter: TIMEOUT_TICKS, 500, clk cycles a player may idle on a turn before forfeit (10 s at the 50 Hz game clock); legal range 2..65535.
REQ-002 Port: clk  in  1  game clock (divided 50 Hz clock); all logic rising-edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: enable  in  1  level; high = shooting phase active.
REQ-005 Port: first_player  in  1  player owning the first turn (0 = A, 1 = B); sampled in IDLE.
REQ-006 Port: pA_btn, pB_btn  in  1 each  debounced button levels, player A / player B.
REQ-007 Port: xy  in  4  target coordinate {X[1:0], Y[1:0]} from switches.
REQ-008 Port: shot_valid  out  1  shot request to game core.
REQ-009 Port: shot_ready  in  1  game core accepts shot.
REQ-010 Port: shot_player  out  1  shooter of the pending shot.
REQ-011 Port: shot_xy  out  4  latched coordinate of the pending shot.
REQ-012 Port: turn  out  1  player currently owning the turn.
REQ-013 Port: illegal  out  1  one-cycle pulse: out-of-turn press.
REQ-014 Port: timeout  out  1  one-cycle pulse: turn forfeited.
REQ-015 Port: shot_count  out  8  accepted shots since IDLE, saturating.

Function
REQ-016 FSM states IDLE, TURN, ISSUE; encoding free.
REQ-017 Press = rising edge of a button level, detected against a registered copy; no press is recognised in the cycle after reset release if the button is held.
REQ-018 IDLE: turn <= first_player every cycle; shot_count <= 0; enable high -> TURN next cycle.
REQ-019 TURN: press by turn player in cycle N -> shot_xy <= xy, shot_player <= turn, state ISSUE, shot_valid = 1 from cycle N+1.
REQ-020 TURN: press by the other player -> illegal = 1 in cycle N+1 for exactly one cycle; press otherwise ignored.
REQ-021 TURN, both presses in the same cycle: turn player's press accepted, illegal pulsed.
REQ-022 ISSUE: shot_valid, shot_xy, shot_player held stable until shot_valid && shot_ready; all presses ignored, no illegal pulse.
REQ-023 Handshake in cycle M -> cycle M+1: shot_valid = 0, turn inverted, state TURN, shot_count + 1 (holds at 255).
REQ-024 shot_ready while shot_valid = 0 is ignored.
REQ-025 enable low in any state -> IDLE next cycle; a pending shot_valid drops without handshake (abort); shot_count cleared.
REQ-026 All outputs registered; no combinational input-to-output path.

Reset
REQ-027 rst low asynchronously forces: state IDLE, shot_valid 0, shot_player 0, shot_xy 0, turn 0, illegal 0, timeout 0, shot_count 0, timeout counter 0, button-edge registers 1.
REQ-028 Reset mid-ISSUE discards the pending shot; no handshake completes.
REQ-029 After rst release, first active edge evaluates IDLE rules.

Configuration
REQ-030 Macro FIRE_TIMEOUT_EN defined: 16-bit idle counter cleared on every entry to TURN, counts each cycle in TURN; at value TIMEOUT_TICKS-1 -> timeout pulse next cycle, turn inverted, counter 0, state stays TURN, shot_count unchanged.
REQ-031 Timeout and a turn-player press in the same cycle: press wins, no timeout.
REQ-032 Macro undefined: no counter logic, timeout tied 0, TIMEOUT_TICKS unused.

Verification
REQ-033 rst low, enable 1, first_player 1, rst released -> turn=1, TURN after 2 clk, shot_valid 0.
REQ-034 TURN A, xy=4'b1001, pA press, shot_ready 0 for 5 cycles then 1 -> shot_valid 1 for 6 cycles, shot_xy=1001, shot_player 0, then turn=1, shot_count=1.
REQ-035 TURN A, pB press -> illegal one-cycle pulse, no shot_valid; pA+pB same cycle -> shot_player 0 and illegal pulse.
REQ-036 ISSUE pending, enable dropped -> shot_valid 0 next cycle, state IDLE, shot_count 0; rst asserted mid-ISSUE -> all outputs reset value immediately.
REQ-037 FIRE_TIMEOUT_EN, TIMEOUT_TICKS=4, no presses in TURN A -> timeout pulse 4 cycles after TURN entry, turn=1; repeats every 4 cycles.
REQ-038 256 handshakes without IDLE -> shot_count holds 255.
